serial_add_ctrl: RTL and testbench

- Bit-serial adder controller. Adds two WIDTH-bit operands using exactly one instance of the team's single-bit full_adder cell, processing one bit per clock from the LSB.
- Sequences operand shifting, carry feedback and result capture, and exposes a start/busy/done handshake.
- Used where adder area matters more than latency, for example in low-rate accumulators and config-path arithmetic.

---
 rtl/serial_add_ctrl.sv | 115 +++++++++++
 tb/tb_serial_add_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell, one bit per clock from the LSB,
// with a start/busy/done handshake and registered sum/carry_out.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit per clock through the full_adder
// DONE  | one-cycle done pulse; start here begins the next operation
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             cy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;

    full_adder u_fa (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .cin  (cy),
        .s    (fa_s),
        .cout (fa_co)
    );

    // Only WIDTH-1 result bits are stored; the final bit comes straight from the cell.
    assign res_nxt  = {fa_s, res};
    assign accept   = start && (state != RUN);
    assign last_bit = (state == RUN) && (cnt == LAST_CNT);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            cy        <= 1'b0;
            cnt       <= '0;
            res       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            cy   <= carry_in;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            cy   <= fa_co;
            cnt  <= cnt + CNT_W'(1);
            res  <= res_nxt[WIDTH-1:1];
            if (last_bit) begin
                sum       <= res_nxt;
                carry_out <= fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised and directed checks of serial_add_ctrl against an arithmetic model.

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    int checks;
    int errors;
    int done_cnt;
    int overlap_cnt;
    logic [W:0] prev_res;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1 && done === 1'b1) overlap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; lat counts edges since acceptance. Returns at the negedge where done is seen.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (done !== 1'b1 && lat < 4 * W) begin
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("result_hold", {23'd0, carry_out, sum}, {23'd0, prev_res});
            @(negedge clk);
            lat++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cin);
        int lat;
        int d0;
        logic [W:0] exp;
        @(negedge clk);
        a = aa; b = bb; carry_in = cin; start = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
        wait_done(0, lat);
        chk("latency", lat, W);
        exp = {1'b0, aa} + {1'b0, bb} + (W+1)'(cin);
        chk("result", {23'd0, carry_out, sum}, {23'd0, exp});
        prev_res = exp;
        @(negedge clk);
        chk("done_pulse_len", {31'd0, done}, 32'd0);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        int lat;
        int d0;
        checks = 0; errors = 0; done_cnt = 0; overlap_cnt = 0;
        prev_res = '0;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {23'd0, carry_out, sum}, 32'd0);
        reset = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);

        // second start during RUN is ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; carry_in = 1'b0; start = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat);
        chk("ignored_latency", lat, W);
        chk("ignored_result", {23'd0, carry_out, sum}, 32'h046);
        prev_res = 9'h046;
        repeat (3) @(negedge clk);
        chk("ignored_done_count", done_cnt - d0, 1);
        chk("ignored_busy_after", {31'd0, busy}, 32'd0);

        // start held high: next operation accepted in the DONE cycle
        @(negedge clk);
        a = 8'h01; b = 8'h01; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done(0, lat);
        chk("b2b_first_latency", lat, W);
        chk("b2b_first_result", {23'd0, carry_out, sum}, 32'h002);
        prev_res = 9'h002;
        a = 8'h80; b = 8'h80;
        @(negedge clk);
        chk("b2b_restart_busy", {31'd0, busy}, 32'd1);
        wait_done(lat + 1, lat);
        start = 1'b0;
        chk("b2b_second_done_edge", lat, 2 * W + 1);
        chk("b2b_second_result", {23'd0, carry_out, sum}, 32'h100);
        prev_res = 9'h100;
        @(negedge clk);
        chk("b2b_idle", {30'd0, busy, done}, 32'd0);

        // asynchronous reset mid-RUN
        @(negedge clk);
        a = 8'h7F; b = 8'h01; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {23'd0, carry_out, sum}, 32'd0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2 * W) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_result_held", {23'd0, carry_out, sum}, 32'd0);
        prev_res = '0;
        run_op(8'h7F, 8'h01, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        chk("busy_done_overlap", overlap_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
